// File: rtl/uart_pkg.sv
// Shared constants and state types for the word-level UART transmitter.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every byte frame.
package uart_pkg;

    localparam int BYTES_PER_WORD = 4;

`ifdef UART_TX_PARITY_EN
    localparam int BITS_PER_FRAME = 11;
`else
    localparam int BITS_PER_FRAME = 10;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND_BYTE,
        NEXT_BYTE,
        DONE
    } tx_word_state_t;

    typedef enum logic [1:0] {
        START,
        DATA,
        PARITY,
        STOP
    } tx_byte_state_t;

    function automatic int clks_per_bit(input int clk_rate, input int baud);
        return (clk_rate * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_word_if.sv
// Word handshake between the debug controller response path and the transmitter.
interface uart_tx_word_if;

    logic        valid;
    logic [31:0] tx_word;
    logic        ready;
    logic        done;

    modport master (
        output valid,
        output tx_word,
        input  ready,
        input  done
    );

    modport slave (
        input  valid,
        input  tx_word,
        output ready,
        output done
    );

endinterface

// File: rtl/uart_tx.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity generation exists only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       stx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_byte_state_t   r_state, w_nextState;
    logic             r_busy, w_nextBusy;
    logic             r_stx, w_nextStx;
    logic [CNT_W-1:0] r_baudCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             w_bitEnd;
    logic             w_accept;
    logic             w_shiftStep;
    logic             w_lastDataStx;

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_parity <= 1'b0;
        else if (w_accept)
            r_parity <= ^data;
    end

    assign w_lastDataStx = r_parity;
`else
    assign w_lastDataStx = 1'b1;
`endif

    // done marks the final stop clock, so a chained start lands with no idle gap
    assign w_bitEnd    = (r_baudCnt == CNT_LAST);
    assign done        = r_busy && (r_state == STOP) && w_bitEnd;
    assign w_accept    = start && (!r_busy || done);
    assign w_shiftStep = r_busy && w_bitEnd && (r_state == DATA);
    assign busy        = r_busy;
    assign stx         = r_stx;

    always_comb begin
        w_nextState = r_state;
        w_nextBusy  = r_busy;
        w_nextStx   = r_stx;
        if (w_accept) begin
            w_nextState = START;
            w_nextBusy  = 1'b1;
            w_nextStx   = 1'b0;
        end else if (r_busy && w_bitEnd) begin
            case (r_state)
                START: begin
                    w_nextState = DATA;
                    w_nextStx   = r_shift[0];
                end
                DATA: begin
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_nextState = PARITY;
`else
                        w_nextState = STOP;
`endif
                        w_nextStx = w_lastDataStx;
                    end else begin
                        w_nextStx = r_shift[1];
                    end
                end
                PARITY: begin
                    w_nextState = STOP;
                    w_nextStx   = 1'b1;
                end
                STOP: begin
                    w_nextState = START;
                    w_nextBusy  = 1'b0;
                    w_nextStx   = 1'b1;
                end
                default: w_nextState = START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= START;
            r_busy  <= 1'b0;
            r_stx   <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_busy  <= w_nextBusy;
            r_stx   <= w_nextStx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
        end else begin
            if (w_accept || !r_busy || w_bitEnd)
                r_baudCnt <= '0;
            else
                r_baudCnt <= r_baudCnt + 1'b1;

            if (w_accept) begin
                r_bitIdx <= '0;
                r_shift  <= data;
            end else if (w_shiftStep) begin
                r_bitIdx <= r_bitIdx + 3'd1;
                r_shift  <= r_shift >> 1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_word.sv
// Word-level UART transmitter: sends a 32-bit word as four big-endian serial bytes.
// Defining UART_TX_PARITY_EN switches every byte to an even-parity frame.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_RATE = -1,
    parameter int BAUD     = -1
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_word_if.slave  bus,
    output logic           stx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    if (CLKS_PER_BIT < 2) begin : g_badRate
        $error("uart_tx_word: CLKS_PER_BIT must be at least 2");
    end

    tx_word_state_t r_state, w_nextState;
    logic [31:0]    r_word;
    logic [1:0]     r_idx, w_byteIdx;
    logic [7:0]     w_txByte;
    logic           w_accept;
    logic           w_advance;
    logic           w_txStart;
    logic           w_txBusy;
    logic           w_txDone;

    assign bus.ready = (r_state == IDLE) || (r_state == DONE);
    assign bus.done  = (r_state == DONE);
    assign w_accept  = bus.valid && bus.ready;
    assign w_advance = (r_state == NEXT_BYTE) && w_txDone && (r_idx != LAST_IDX);

    // NEXT_BYTE chains the following byte in the serializer's final stop clock
    always_comb begin
        w_nextState = r_state;
        w_txStart   = 1'b0;
        w_byteIdx   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_nextState = SEND_BYTE;
            end
            SEND_BYTE: begin
                if (!w_txBusy) begin
                    w_txStart   = 1'b1;
                    w_nextState = NEXT_BYTE;
                end
            end
            NEXT_BYTE: begin
                if (w_txDone) begin
                    if (r_idx == LAST_IDX) begin
                        w_nextState = DONE;
                    end else begin
                        w_txStart = 1'b1;
                        w_byteIdx = r_idx + 2'd1;
                    end
                end
            end
            DONE: begin
                w_nextState = w_accept ? SEND_BYTE : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_txByte = r_word[31:24];
        case (w_byteIdx)
            2'd0: w_txByte = r_word[31:24];
            2'd1: w_txByte = r_word[23:16];
            2'd2: w_txByte = r_word[15:8];
            2'd3: w_txByte = r_word[7:0];
            default: w_txByte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_word <= bus.tx_word;
            r_idx  <= '0;
        end else if (w_advance) begin
            r_idx <= w_byteIdx;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_txStart),
        .data  (w_txByte),
        .stx   (stx),
        .busy  (w_txBusy),
        .done  (w_txDone)
    );

endmodule

// File: tb/tb_uart_tx_word.sv
// Scoreboard bench for uart_tx_word: bytes are queued on accept and decoded from stx.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_word;

    localparam int CLK_RATE = 10;
    localparam int BAUD     = 1_000_000;
    localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CLKS = 4 * FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic stx;

    uart_tx_word_if bus ();

    uart_tx_word #(
        .CLK_RATE(CLK_RATE),
        .BAUD    (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .stx  (stx)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int acceptCyc = 0;
    int doneCount = 0;
    logic [7:0] expQ[$];
    bit monOn = 1'b0;

    bit         inFrame = 1'b0;
    int         k, startLow, stopHigh;
    logic [7:0] rxByte;
    logic       rxPar;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) doneCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
        checks++;
        if (observed !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", tag, observed, required, $time);
        end
    endtask

    task automatic finishFrame();
        logic [7:0] e;
        checkOutput("frameExpected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rxByte", 32'(rxByte), 32'(e));
`ifdef UART_TX_PARITY_EN
            checkOutput("parityBit", 32'(rxPar), 32'(^e));
`endif
        end
        checkOutput("startLowClks", startLow, CPB);
        checkOutput("stopHighClks", stopHigh, CPB);
    endtask

    // Serial monitor: sample every clock of a frame, decode at bit centres
    always @(negedge clk) begin
        if (!monOn || !rst_n) begin
            inFrame = 1'b0;
        end else begin
            if (!inFrame && stx === 1'b0) begin
                inFrame  = 1'b1;
                k        = 0;
                startLow = 0;
                stopHigh = 0;
                rxByte   = '0;
                rxPar    = 1'b0;
            end
            if (inFrame) begin
                if (k / CPB == 0 && stx === 1'b0) startLow++;
                if (k / CPB >= 1 && k / CPB <= 8 && k % CPB == CPB / 2) rxByte[k / CPB - 1] = stx;
`ifdef UART_TX_PARITY_EN
                if (k / CPB == 9 && k % CPB == CPB / 2) rxPar = stx;
`endif
                if (k / CPB == FRAME_BITS - 1 && stx === 1'b1) stopHigh++;
                k++;
                if (k == FRAME_BITS * CPB) begin
                    inFrame = 1'b0;
                    finishFrame();
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] word, input bit holdValid, output int waited);
        waited      = 0;
        bus.valid   = 1'b1;
        bus.tx_word = word;
        while (bus.ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (bus.ready !== 1'b1) begin
            checkOutput("acceptTimeout", waited, 0);
            bus.valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acceptCyc = cyc;
            expQ.push_back(word[31:24]);
            expQ.push_back(word[23:16]);
            expQ.push_back(word[15:8]);
            expQ.push_back(word[7:0]);
            if (!holdValid) bus.valid = 1'b0;
        end
    endtask

    // Called right after an accept; ends on the negedge where done is high
    task automatic checkWordTiming();
        bit readyStayedLow = 1'b1;
        @(negedge clk);
        checkOutput("readyDropAfterAccept", 32'(bus.ready), 32'd0);
        checkOutput("stxIdleAtAccept", 32'(stx), 32'd1);
        @(negedge clk);
        checkOutput("stxStartLatency", 32'(stx), 32'd0);
        repeat (WORD_CLKS - 1) begin
            @(negedge clk);
            if (bus.ready !== 1'b0 || bus.done !== 1'b0) readyStayedLow = 1'b0;
        end
        checkOutput("readyLowDuringWord", 32'(readyStayedLow), 32'd1);
        @(negedge clk);
        checkOutput("doneAtAcceptPlusWord", 32'(bus.done), 32'd1);
        checkOutput("readyInDone", 32'(bus.ready), 32'd1);
        checkOutput("doneLatency", cyc - acceptCyc, WORD_CLKS + 1);
    endtask

    task automatic waitDone();
        int n = 0;
        while (bus.done !== 1'b1 && n < 2 * WORD_CLKS) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", 32'(bus.done), 32'd1);
        checkOutput("doneLatencyBusy", cyc - acceptCyc, WORD_CLKS + 1);
    endtask

    initial begin
        int waited;
        int doneBefore;
        bit stxStayedHigh;

        bus.valid   = 1'b0;
        bus.tx_word = '0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetStx", 32'(stx), 32'd1);
        checkOutput("resetReady", 32'(bus.ready), 32'd1);
        checkOutput("resetDone", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        monOn = 1'b1;
        @(negedge clk);

        applyStimulus(32'hDEADBEEF, 1'b0, waited);
        checkWordTiming();
        @(negedge clk);
        checkOutput("doneOneShot", 32'(bus.done), 32'd0);

        // Busy-time changes must not disturb the word in flight
        applyStimulus(32'hA5C30F96, 1'b0, waited);
        repeat (50) @(negedge clk);
        bus.tx_word = 32'hFFFFFFFF;
        bus.valid   = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (100) @(negedge clk);
        bus.valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.valid = 1'b0;
        waitDone();
        @(negedge clk);

        // Back-to-back words with valid held high across the DONE cycle
        applyStimulus(32'h01234567, 1'b1, waited);
        bus.tx_word = 32'h89ABCDEF;
        checkWordTiming();
        applyStimulus(32'h89ABCDEF, 1'b0, waited);
        checkOutput("b2bAcceptInDone", waited, 0);
        checkWordTiming();
        @(negedge clk);

        applyStimulus(32'h00000000, 1'b0, waited);
        checkWordTiming();
        @(negedge clk);
        applyStimulus(32'hFFFFFFFF, 1'b0, waited);
        checkWordTiming();
        @(negedge clk);

        // Reset during the start bit of the second byte
        applyStimulus(32'h5A5A5A5A, 1'b0, waited);
        repeat (106) @(negedge clk);
        checkOutput("stxLowBeforeReset", 32'(stx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetStx", 32'(stx), 32'd1);
        checkOutput("asyncResetReady", 32'(bus.ready), 32'd1);
        checkOutput("asyncResetDone", 32'(bus.done), 32'd0);
        expQ.delete();
        doneBefore = doneCount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stxStayedHigh = 1'b1;
        repeat (WORD_CLKS + 20) begin
            @(negedge clk);
            if (stx !== 1'b1) stxStayedHigh = 1'b0;
        end
        checkOutput("noDoneAfterReset", doneCount - doneBefore, 0);
        checkOutput("stxIdleAfterReset", 32'(stxStayedHigh), 32'd1);

        applyStimulus(32'h13579BDF, 1'b0, waited);
        checkWordTiming();

        repeat (5) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Word-level UART transmitter; the transmit-side counterpart of the word receiver on the debugger link.
- Accepts one 32-bit word through a valid/ready handshake.
- Serializes the word as 4 back-to-back 8N1 bytes, big-endian (bits [31:24] first), on stx.
- Sits between the debug controller's response path and the board TX pin.

Parameters:
- CLK_RATE, -1, rate of clk in MHz; must be overridden.
- BAUD, -1, serial rate in bits/s; must be overridden.
- Derived constant CLKS_PER_BIT = CLK_RATE*1_000_000/BAUD. Elaboration error if CLKS_PER_BIT < 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid  input  1  tx_word holds a word to send.
- tx_word  input  32  word to transmit; sampled only on accept.
- ready  output  1  block idle and able to accept; accept = valid && ready.
- done  output  1  one-shot; high exactly one cycle after the last stop bit completes.
- stx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync release): stx=1, ready=1, done=0, FSM=IDLE, byte index=0, bit and baud counters=0, word register=0.
- FSM states: IDLE, SEND_BYTE, NEXT_BYTE, DONE.
- IDLE: ready=1. On accept, latch tx_word and set byte index=0, then go to SEND_BYTE. ready drops the cycle after accept.
- SEND_BYTE: pulse start to the byte serializer with byte = word[31-8*idx -: 8]. Wait for the serializer's done, then go to NEXT_BYTE.
- NEXT_BYTE: if idx==3, go to DONE; else idx+1 and return to SEND_BYTE.
- Inter-byte gap: the next start bit begins on the clock right after the previous stop bit period ends. There is no extra idle time between bytes, so the serializer must accept start in the same cycle it asserts done.
- DONE: done=1 for one cycle, ready=1 in that same cycle, then go to IDLE. A valid arriving during DONE is accepted and starts a new word; done and accept coincide.
- Byte frame: start bit (0) for CLKS_PER_BIT clocks, then 8 data bits LSB first, CLKS_PER_BIT clocks each, then stop bit (1) for CLKS_PER_BIT clocks.
- Latency: stx falls on the 1st clock edge after the accept edge. Word frame length = 40*CLKS_PER_BIT clocks. done rises 40*CLKS_PER_BIT+1 clocks after accept.
- stx is registered (glitch-free).
- Changes to tx_word/valid while ready=0 are ignored. No buffering; the upstream holds valid until ready.
- Reset mid-word: stx returns high immediately (async); the partial frame is abandoned; no done pulse.
- Counters sized $clog2(CLKS_PER_BIT); the baud counter wraps to 0 at CLKS_PER_BIT-1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: each byte carries an even-parity bit (XOR of the data bits) between the 8th data bit and the stop bit. Frame is 11 bits; word frame = 44*CLKS_PER_BIT clocks.
- Undefined: 8N1 as above, and no parity logic is synthesized.

Decomposition:
- Shared package uart_pkg:
  - function clks_per_bit(clk_rate, baud)
  - BYTES_PER_WORD=4
  - BITS_PER_FRAME (10, or 11 under the macro)
  - word-level state typedef tx_word_state_t
  - byte-level state typedef tx_byte_state_t {START, DATA, PARITY, STOP}
- Sub-module uart_tx: byte serializer.
  - Ports: clk, rst_n, start, data[7:0], stx, busy, done.
  - Owns the baud counter, bit index, shift register and parity.
  - uart_tx_word holds only the word register, byte index and word FSM.

Test Plan (CLK_RATE=10, BAUD=1_000_000, CLKS_PER_BIT=10):
- Reset: hold rst_n=0 mid-simulation, including during a frame -> stx=1, ready=1, done=0 asynchronously; no done pulse afterwards.
- Send 0xDEADBEEF -> bytes DE, AD, BE, EF decoded by sampling stx at bit centers. DE bits appear as 0,1,1,1,1,0,1,1. stx falls 1 clk after accept; done at accept+401 clks; ready=0 throughout.
- Back-to-back: valid held high with 0x01234567 then 0x89ABCDEF -> second accept in the DONE cycle; second start bit begins 1 clk after done; 8 bytes total with no idle bit between words beyond one cycle.
- Busy-time changes: change tx_word to 0xFFFFFFFF and pulse valid during transmission -> ignored; original word is sent unchanged.
- Boundary data: 0x00000000 and 0xFFFFFFFF -> every stop bit stays high for exactly 10 clks; each start bit is exactly 10 clks low.
- UART_TX_PARITY_EN: 0xDEADBEEF -> parity bits 0, 1, 0, 1 (popcounts 6, 5, 6, 7); done at accept+441 clks.
